// File: rtl/shape_editor_pkg.sv
// shape_pkg: shared enums and angle bounds for the shape edit engine
package shape_pkg;
  typedef enum logic [1:0] {MOVE, XFORM, MANAGE, COLOR} edit_mode_t;
  typedef enum logic [1:0] {IDLE, APPLY, SELECT, DONE} edit_state_t;
  localparam int ANG_MIN = -180;
  localparam int ANG_MAX = 179;
endpackage

// File: rtl/step_sat_wrap.sv
// step_sat_wrap: next value one step up and one step down, saturated or wrapped into [lo, hi]
module step_sat_wrap #(
  parameter int W = 16
) (
  input  logic [W-1:0] val_i,
  input  logic [W-1:0] step_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] hi_i,
  input  logic         wrap_i,
  output logic [W-1:0] inc_o,
  output logic [W-1:0] dec_o
);
  logic signed [W:0] v, s, l, h, span, up, dn;
  assign v    = {val_i[W-1], val_i};
  assign s    = {1'b0, step_i};
  assign l    = {lo_i[W-1], lo_i};
  assign h    = {hi_i[W-1], hi_i};
  assign span = h - l + (W+1)'(1);
  assign up   = v + s;
  assign dn   = v - s;
  assign inc_o = W'(up > h ? (wrap_i ? up - span : h) : up);
  assign dec_o = W'(dn < l ? (wrap_i ? dn + span : l) : dn);
endmodule

// File: rtl/shape_editor.sv
// shape_editor: frame-synchronised edit engine for the per-slot shape property registers
module shape_editor
  import shape_pkg::*;
#(
  parameter int NSHP      = 4,
  parameter int INTW      = 16,
  parameter int PIXLW     = 12,
  parameter int SCR_W     = 800,
  parameter int SCR_H     = 600,
  parameter int NTYPE     = 4,
  parameter int SIZE_MAX  = 255,
  parameter int INIT_SIZE = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame,
  input  logic [1:0]               mode,
  input  logic [1:0]               mag,
  input  logic                     l_p,
  input  logic                     r_p,
  input  logic                     u_p,
  input  logic                     d_p,
  input  logic                     l_once,
  input  logic                     r_once,
  input  logic                     c_once,
  input  logic [PIXLW-1:0]         pick_color,
  output logic                     done,
  output logic [$clog2(NSHP)-1:0]  sel,
  output logic [INTW-1:0]          count,
  output logic [NSHP-1:0]          active,
  output logic [NSHP*INTW-1:0]     shp_ty,
  output logic [NSHP*INTW-1:0]     shp_x,
  output logic [NSHP*INTW-1:0]     shp_y,
  output logic [NSHP*INTW-1:0]     shp_size,
  output logic [NSHP*INTW-1:0]     shp_angle,
  output logic [NSHP*PIXLW-1:0]    shp_color
);
  localparam int SW = $clog2(NSHP);

  edit_state_t      state_q;
  edit_mode_t       mode_q;
  logic [INTW-1:0]  x_q [NSHP];
  logic [INTW-1:0]  y_q [NSHP];
  logic [INTW-1:0]  size_q [NSHP];
  logic [INTW-1:0]  ang_q [NSHP];
  logic [INTW-1:0]  ty_q [NSHP];
  logic [PIXLW-1:0] col_q [NSHP];
  logic [NSHP-1:0]  act_q;
  logic [INTW-1:0]  cnt_q;
  logic [SW-1:0]    sel_q, scan_q, free_d;
  logic             done_q, free_ok_d;
  logic [INTW-1:0]  step;
  logic [INTW-1:0]  x_inc, x_dec, y_inc, y_dec, s_inc, s_dec, a_inc, a_dec;
  logic [INTW-1:0]  x_d, y_d, size_d, ang_d, ty_d;

  function automatic logic [SW-1:0] nxt(input logic [SW-1:0] v);
    return (v == SW'(NSHP-1)) ? '0 : v + SW'(1);
  endfunction

  assign step = INTW'(1) << mag;

  step_sat_wrap #(.W(INTW)) u_x (
    .val_i(x_q[sel_q]), .step_i(step), .lo_i('0), .hi_i(INTW'(SCR_W-1)),
    .wrap_i(1'b0), .inc_o(x_inc), .dec_o(x_dec));
  step_sat_wrap #(.W(INTW)) u_y (
    .val_i(y_q[sel_q]), .step_i(step), .lo_i('0), .hi_i(INTW'(SCR_H-1)),
    .wrap_i(1'b0), .inc_o(y_inc), .dec_o(y_dec));
  step_sat_wrap #(.W(INTW)) u_size (
    .val_i(size_q[sel_q]), .step_i(step), .lo_i(INTW'(1)), .hi_i(INTW'(SIZE_MAX)),
    .wrap_i(1'b0), .inc_o(s_inc), .dec_o(s_dec));
  step_sat_wrap #(.W(INTW)) u_ang (
    .val_i(ang_q[sel_q]), .step_i(step), .lo_i(INTW'(ANG_MIN)), .hi_i(INTW'(ANG_MAX)),
    .wrap_i(1'b1), .inc_o(a_inc), .dec_o(a_dec));

  // Candidate values for the selected slot; left/up win over right/down
  always_comb begin
    x_d    = l_p ? x_dec : r_p ? x_inc : x_q[sel_q];
    y_d    = u_p ? y_dec : d_p ? y_inc : y_q[sel_q];
    ang_d  = l_p ? a_dec : r_p ? a_inc : ang_q[sel_q];
    size_d = u_p ? s_inc : d_p ? s_dec : size_q[sel_q];
    ty_d   = !c_once ? ty_q[sel_q] :
             (ty_q[sel_q] >= INTW'(NTYPE-1)) ? '0 : ty_q[sel_q] + INTW'(1);
  end

  // Lowest inactive slot, searched from the top so the lowest index wins
  always_comb begin
    free_ok_d = 1'b0;
    free_d    = '0;
    for (int k = NSHP-1; k >= 0; k--) begin
      if (!act_q[k]) begin
        free_ok_d = 1'b1;
        free_d    = SW'(k);
      end
    end
  end

  // Edit FSM holding all slot registers; one edit per accepted frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= MOVE;
      done_q  <= 1'b0;
      sel_q   <= '0;
      scan_q  <= '0;
      cnt_q   <= INTW'(1);
      act_q   <= NSHP'(1);
      for (int k = 0; k < NSHP; k++) begin
        x_q[k]    <= (k == 0) ? INTW'(SCR_W/2) : '0;
        y_q[k]    <= (k == 0) ? INTW'(SCR_H/2) : '0;
        size_q[k] <= (k == 0) ? INTW'(INIT_SIZE) : '0;
        ang_q[k]  <= '0;
        ty_q[k]   <= '0;
        col_q[k]  <= (k == 0) ? '1 : '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame) begin
            mode_q  <= edit_mode_t'(mode);
            state_q <= APPLY;
          end
        end
        APPLY: begin
          state_q <= DONE;
          case (mode_q)
            MOVE: begin
              x_q[sel_q] <= x_d;
              y_q[sel_q] <= y_d;
            end
            XFORM: begin
              ang_q[sel_q]  <= ang_d;
              size_q[sel_q] <= size_d;
              ty_q[sel_q]   <= ty_d;
            end
            COLOR: begin
              if (c_once) col_q[sel_q] <= pick_color;
            end
            MANAGE: begin
              if (l_once) begin
                if (cnt_q > INTW'(1)) begin
                  act_q[sel_q] <= 1'b0;
                  col_q[sel_q] <= '0;
                  cnt_q        <= cnt_q - INTW'(1);
                  scan_q       <= nxt(sel_q);
                  state_q      <= SELECT;
                end
              end else if (r_once) begin
                if (free_ok_d) begin
                  x_q[free_d]    <= INTW'(SCR_W/2);
                  y_q[free_d]    <= INTW'(SCR_H/2);
                  size_q[free_d] <= INTW'(INIT_SIZE);
                  ang_q[free_d]  <= '0;
                  ty_q[free_d]   <= '0;
                  col_q[free_d]  <= '1;
                  act_q[free_d]  <= 1'b1;
                  cnt_q          <= cnt_q + INTW'(1);
                  sel_q          <= free_d;
                end
              end else if (c_once) begin
                scan_q  <= nxt(sel_q);
                state_q <= SELECT;
              end
            end
          endcase
        end
        SELECT: begin
          if (act_q[scan_q]) begin
            sel_q   <= scan_q;
            state_q <= DONE;
          end else begin
            scan_q <= nxt(scan_q);
            if (nxt(scan_q) == sel_q) state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done   = done_q;
  assign sel    = sel_q;
  assign count  = cnt_q;
  assign active = act_q;

  for (genvar k = 0; k < NSHP; k++) begin : g_pack
    assign shp_x[k*INTW +: INTW]      = x_q[k];
    assign shp_y[k*INTW +: INTW]      = y_q[k];
    assign shp_size[k*INTW +: INTW]   = size_q[k];
    assign shp_angle[k*INTW +: INTW]  = ang_q[k];
    assign shp_ty[k*INTW +: INTW]     = ty_q[k];
    assign shp_color[k*PIXLW +: PIXLW] = col_q[k];
  end
endmodule

// File: doc/shape_editor.md
# shape_editor

Frame-synchronised edit engine holding the property registers of up to `NSHP` shapes for the tangram renderer. It generalises the single-shape control path to a selectable current shape, variable step magnitude, slot allocate/free and wrap/saturate arithmetic. Once per frame it applies one edit command, taken from the conditioned button inputs and the mode, to the selected slot. It sits between the `input_mode` button conditioners and the per-shape `render_shape` instances.

## Interface

Parameters:
- `NSHP` = 4: number of shape slots; must be ≥2.
- `INTW` = 16: width of every shape property and of `count`; angle is signed.
- `PIXLW` = 12: colour width.
- `SCR_W` = 800, `SCR_H` = 600: screen bounds for x and y.
- `NTYPE` = 4: number of shape types.
- `SIZE_MAX` = 255: maximum size.
- `INIT_SIZE` = 10: size given to a newly allocated slot.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous, active-low.
- `frame` in 1: one-cycle pulse at the start of each frame.
- `mode` in 2: 0 = move, 1 = transform, 2 = manage, 3 = colour.
- `mag` in 2: step magnitude; step = 1 << `mag`.
- `l_p`, `r_p`, `u_p`, `d_p` in 1 each: held/repeat button levels.
- `l_once`, `r_once`, `c_once` in 1 each: single-shot button events.
- `pick_color` in `PIXLW`: colour offered by the colour picker.
- `done` out 1: one-cycle pulse marking the end of the edit; drives the button-conditioner clear.
- `sel` out `$clog2(NSHP)`: index of the selected slot.
- `count` out `INTW`: number of active slots.
- `active` out `NSHP`: slot-enable mask.
- `shp_ty`, `shp_x`, `shp_y`, `shp_size`, `shp_angle` out `NSHP*INTW` each: packed per slot, slot k at bits `[k*INTW +: INTW]`.
- `shp_color` out `NSHP*PIXLW`: packed per slot in the same way.

## Operation

- States are IDLE → APPLY → (SELECT) → DONE → IDLE.
- IDLE: on `frame`, go to APPLY. `mode` is sampled in IDLE and held through APPLY.
- APPLY edits only slot `sel`, according to mode:
  - Move: `u_p` has priority over `d_p`; `l_p` has priority over `r_p`. x and y change by step and saturate to [0, `SCR_W`-1] and [0, `SCR_H`-1]. Example: x = 2, step = 4, left gives x = 0.
  - Transform:
    - `l_p`/`r_p` decrement/increment the angle by step, wrapping within [-180, 179]. Examples: -179 - 4 = 177; 178 + 4 = -178.
    - `u_p`/`d_p` change size, saturating to [1, `SIZE_MAX`].
    - `c_once` advances the type: (ty + 1) mod `NTYPE`.
  - Manage:
    - `l_once` has priority. If `count` > 1, it clears `active[sel]`, sets `shp_color[sel]` to 0, decrements `count` and goes to SELECT.
    - Otherwise `r_once` allocates the lowest inactive slot, if any. The slot gets x = `SCR_W`/2, y = `SCR_H`/2, size = `INIT_SIZE`, angle = 0, ty = 0, colour = all-ones. The slot is marked active, `count` increments and `sel` moves to that slot.
    - With no free slot, `r_once` is a no-op.
    - Otherwise `c_once` goes to SELECT.
  - Colour: `c_once` writes `pick_color` into `shp_color[sel]`.
- SELECT: scans one index per cycle from `sel`+1, wrapping modulo `NSHP`, and stops at the first active slot; that slot becomes `sel`. At most `NSHP`-1 cycles; if no other slot is active, `sel` is unchanged. Then go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `frame` arriving outside IDLE is ignored.
- Inactive slots keep their other properties but are excluded from selection.

## Timing

- Reset state, asserted asynchronously:
  - state IDLE, `done` 0, `sel` 0, `count` 1, `active` = 1 (slot 0 only).
  - Slot 0: x = `SCR_W`/2, y = `SCR_H`/2, size = `INIT_SIZE`, angle 0, ty 0, colour all-ones.
  - All other slots: all properties 0.
- Reset mid-edit aborts the edit with no partial update; no `done` pulse is produced.
- Edit latency: the register update is visible 2 cycles after `frame`. `done` asserts 3 cycles after `frame` without SELECT, and at most 3 + (`NSHP`-1) cycles with SELECT.
- All outputs are registered. Property outputs change only on the APPLY (or SELECT, for `sel`) clock edge.
- Step arithmetic is done at `INTW`+1 bits, so saturation and wrap cannot overflow.

## Structure

- Package `shape_pkg`:
  - `edit_mode_t` enum: MOVE, XFORM, MANAGE, COLOR.
  - `edit_state_t` enum: IDLE, APPLY, SELECT, DONE.
  - Angle bounds ANG_MIN = -180, ANG_MAX = 179.
- Sub-module `step_sat_wrap`: combinational, with inputs value, step, lo, hi and a wrap/saturate select; outputs the next value for the increment and decrement directions.
  - Instantiated for x, y, size and angle on the selected slot only.
- The lowest-free-slot priority encoder is written inline.

## Test plan

- Reset, then one frame with mode 0, `r_p` = 1, `mag` = 2 → slot 0 x goes 400 → 404; `done` pulses 3 cycles after `frame`.
- Mode 1, angle 178, `mag` = 2, `r_p` → angle -178. Mode 1, size 1, `d_p` → size stays 1.
- Mode 2, `r_once` three times → `count` = 4, `sel` = 3. A fourth `r_once` → no change.
- Mode 2, with `active` = 1011b and `sel` = 1, `l_once` → `active` = 1001b, `count` = 2, slot 1 colour 0, `sel` = 3 after SELECT.
- Mode 2, `c_once` with `active` = 1001b and `sel` = 3 → `sel` wraps to 0. With only slot 0 active, `c_once` → `sel` stays 0.
- `rst` low during SELECT → all outputs at reset values immediately, with no `done` pulse. A `frame` during DONE → ignored.
